// File: rtl/bldc_drive_sequencer.sv
// BLDC drive sequencer: rate-limited signed duty command with a zero-crossing
// dead period on reversal, plus hall-code and stall supervision.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | drive off, pwm_cmd 0, counters cleared
// RUN   | pwm_cmd ramps toward the goal once per ramp tick
// DEAD  | pwm_cmd held at 0 before the direction flip
// FAULT | pwm_cmd 0, fault_code latched until enable drops
module bldc_drive_sequencer #(
    parameter int RAMP_DIV        = 1024,
    parameter int RAMP_STEP       = 8,
    parameter int DEAD_CYCLES     = 256,
    parameter int STALL_CYCLES    = 1048576,
    parameter int HALL_BAD_CYCLES = 4
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               enable,
    input  logic signed [10:0] target_pwm,
    input  logic               hall1,
    input  logic               hall2,
    input  logic               hall3,
    output logic signed [10:0] pwm_cmd,
    output logic               dir,
    output logic [1:0]         state,
    output logic               fault,
    output logic [1:0]         fault_code,
    output logic [2:0]         hall_sync
);

    localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam int SW = $clog2(STALL_CYCLES + 1);
    localparam int HW = $clog2(HALL_BAD_CYCLES + 1);

    localparam logic signed [11:0] STEP_S  = 12'(RAMP_STEP);
    localparam logic signed [11:0] PWM_MAX = 12'sd1023;
    localparam logic signed [11:0] PWM_MIN = -12'sd1023;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DEAD  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t             st_q, st_d;
    logic [2:0]         hall_meta, hall_prev;
    logic [RW-1:0]      ramp_q, ramp_d;
    logic [DW-1:0]      dead_q, dead_d;
    logic [SW-1:0]      stall_q, stall_d;
    logic [HW-1:0]      hbad_q, hbad_d;
    logic signed [10:0] pwm_d, pwm_ramped;
    logic               dir_d;
    logic [1:0]         code_d;

    logic signed [11:0] tgt, goal, pwm_ext, diff, diff_abs, stepped;
    logic               t_nz, t_neg, mismatch, ramp_tick;
    logic               hall_bad, hall_same, hall_fault, stall_fault;

    // -1024 has no positive counterpart, so it is folded to -1023.
    assign tgt      = (target_pwm == 11'b100_0000_0000) ? PWM_MIN : {target_pwm[10], target_pwm};
    assign t_nz     = (tgt != '0);
    assign t_neg    = tgt[11];
    assign mismatch = t_nz && (t_neg != dir);
    assign goal     = mismatch ? 12'sd0 : tgt;
    assign pwm_ext  = {pwm_cmd[10], pwm_cmd};
    assign diff     = goal - pwm_ext;
    assign diff_abs = diff[11] ? -diff : diff;
    assign ramp_tick = (ramp_q == RW'(RAMP_DIV - 1));

    always_comb begin
        stepped = goal;
        if (diff_abs > STEP_S) begin
            stepped = diff[11] ? (pwm_ext - STEP_S) : (pwm_ext + STEP_S);
        end
        pwm_ramped = stepped[10:0];
        if (stepped > PWM_MAX) begin
            pwm_ramped = 11'sd1023;
        end else if (stepped < PWM_MIN) begin
            pwm_ramped = -11'sd1023;
        end
    end

    assign hall_bad    = (hall_sync == 3'b000) || (hall_sync == 3'b111);
    assign hall_same   = (hall_sync == hall_prev);
    assign hall_fault  = hall_bad && (hbad_q >= HW'(HALL_BAD_CYCLES - 1));
    assign stall_fault = (pwm_cmd != '0) && hall_same && (stall_q >= SW'(STALL_CYCLES - 1));

    always_comb begin
        st_d    = st_q;
        pwm_d   = pwm_cmd;
        dir_d   = dir;
        code_d  = fault_code;
        ramp_d  = ramp_q;
        dead_d  = dead_q;
        stall_d = stall_q;
        hbad_d  = hbad_q;
        case (st_q)
            ST_IDLE: begin
                pwm_d   = '0;
                code_d  = 2'b00;
                ramp_d  = '0;
                dead_d  = '0;
                stall_d = '0;
                hbad_d  = '0;
                if (enable) begin
                    st_d = ST_RUN;
                    if (t_nz) dir_d = t_neg;
                end
            end
            ST_RUN: begin
                hbad_d  = hall_bad ? hbad_q + 1'b1 : '0;
                stall_d = ((pwm_cmd != '0) && hall_same) ? stall_q + 1'b1 : '0;
                if (hall_fault) begin
                    st_d   = ST_FAULT;
                    code_d = 2'b01;
                    pwm_d  = '0;
                end else if (stall_fault) begin
                    st_d   = ST_FAULT;
                    code_d = 2'b10;
                    pwm_d  = '0;
                end else if (!enable) begin
                    st_d    = ST_IDLE;
                    pwm_d   = '0;
                    stall_d = '0;
                    hbad_d  = '0;
                end else if ((pwm_cmd == '0) && mismatch) begin
                    st_d   = ST_DEAD;
                    dead_d = DW'(DEAD_CYCLES - 1);
                end else begin
                    ramp_d = ramp_tick ? '0 : ramp_q + 1'b1;
                    if (ramp_tick) pwm_d = pwm_ramped;
                end
            end
            ST_DEAD: begin
                pwm_d   = '0;
                stall_d = '0;
                hbad_d  = hall_bad ? hbad_q + 1'b1 : '0;
                if (hall_fault) begin
                    st_d   = ST_FAULT;
                    code_d = 2'b01;
                end else if (!enable) begin
                    st_d   = ST_IDLE;
                    hbad_d = '0;
                    dead_d = '0;
                end else if (dead_q == '0) begin
                    st_d   = ST_RUN;
                    dir_d  = ~dir;
                    ramp_d = '0;
                end else begin
                    dead_d = dead_q - 1'b1;
                end
            end
            ST_FAULT: begin
                pwm_d = '0;
                if (!enable) begin
                    st_d    = ST_IDLE;
                    code_d  = 2'b00;
                    ramp_d  = '0;
                    dead_d  = '0;
                    stall_d = '0;
                    hbad_d  = '0;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            st_q       <= ST_IDLE;
            pwm_cmd    <= '0;
            dir        <= 1'b0;
            fault_code <= 2'b00;
            hall_meta  <= '0;
            hall_sync  <= '0;
            hall_prev  <= '0;
            ramp_q     <= '0;
            dead_q     <= '0;
            stall_q    <= '0;
            hbad_q     <= '0;
        end else begin
            st_q       <= st_d;
            pwm_cmd    <= pwm_d;
            dir        <= dir_d;
            fault_code <= code_d;
            hall_meta  <= {hall1, hall2, hall3};
            hall_sync  <= hall_meta;
            hall_prev  <= hall_sync;
            ramp_q     <= ramp_d;
            dead_q     <= dead_d;
            stall_q    <= stall_d;
            hbad_q     <= hbad_d;
        end
    end

    assign state = st_q;
    assign fault = (st_q == ST_FAULT);

endmodule

// File: tb/tb_bldc_drive_sequencer.sv
// Scoreboard bench for bldc_drive_sequencer: a behavioural model predicts the
// outputs after every clock edge and a monitor compares them on the falling edge.
module tb_bldc_drive_sequencer;

    localparam int RAMP_DIV        = 4;
    localparam int RAMP_STEP       = 100;
    localparam int DEAD_CYCLES     = 8;
    localparam int STALL_CYCLES    = 64;
    localparam int HALL_BAD_CYCLES = 3;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DEAD  = 2;
    localparam int M_FAULT = 3;

    logic               CLK = 1'b0;
    logic               RESET_N = 1'b1;
    logic               enable = 1'b0;
    logic signed [10:0] target_pwm = '0;
    logic               hall1 = 1'b0, hall2 = 1'b0, hall3 = 1'b1;
    logic signed [10:0] pwm_cmd;
    logic               dir;
    logic [1:0]         state;
    logic               fault;
    logic [1:0]         fault_code;
    logic [2:0]         hall_sync;

    bldc_drive_sequencer #(
        .RAMP_DIV(RAMP_DIV), .RAMP_STEP(RAMP_STEP), .DEAD_CYCLES(DEAD_CYCLES),
        .STALL_CYCLES(STALL_CYCLES), .HALL_BAD_CYCLES(HALL_BAD_CYCLES)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .enable(enable), .target_pwm(target_pwm),
        .hall1(hall1), .hall2(hall2), .hall3(hall3),
        .pwm_cmd(pwm_cmd), .dir(dir), .state(state), .fault(fault),
        .fault_code(fault_code), .hall_sync(hall_sync)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int pwm; int dir; int st; int flt; int code; int hs;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_fail = 0;

    // Reference model state (plain integers)
    int m_st = M_IDLE, m_pwm = 0, m_dir = 0, m_code = 0;
    int m_meta = 0, m_sync = 0, m_prev = 0;
    int m_since = 0, m_dead_left = 0, m_hbad = 0, m_stall = 0;

    function automatic int step_toward(input int cur, input int goal);
        int d, r;
        d = goal - cur;
        if (d <= RAMP_STEP && d >= -RAMP_STEP) return goal;
        r = cur + ((d > 0) ? RAMP_STEP : -RAMP_STEP);
        if (r > 1023) r = 1023;
        if (r < -1023) r = -1023;
        return r;
    endfunction

    task automatic go_fault(input int c);
        m_st = M_FAULT; m_code = c; m_pwm = 0;
    endtask

    task automatic go_idle();
        m_st = M_IDLE; m_pwm = 0; m_hbad = 0; m_stall = 0; m_code = 0;
    endtask

    task automatic model_step();
        int t, goal, nh, ns;
        bit bad, same, mism, hf, sf;
        t = target_pwm;
        if (t == -1024) t = -1023;
        bad  = (m_sync == 0) || (m_sync == 7);
        same = (m_sync == m_prev);
        nh   = bad ? m_hbad + 1 : 0;
        ns   = (m_pwm != 0 && same) ? m_stall + 1 : 0;
        hf   = bad && (nh >= HALL_BAD_CYCLES);
        sf   = (m_pwm != 0) && same && (ns >= STALL_CYCLES);
        mism = (t != 0) && ((t < 0) != (m_dir != 0));
        goal = mism ? 0 : t;
        case (m_st)
            M_IDLE: if (enable) begin
                m_st = M_RUN;
                if (t != 0) m_dir = (t < 0) ? 1 : 0;
                m_since = 0;
            end
            M_RUN: begin
                if (hf) go_fault(1);
                else if (sf) go_fault(2);
                else if (!enable) go_idle();
                else begin
                    m_hbad = nh; m_stall = ns;
                    if (m_pwm == 0 && mism) begin
                        m_st = M_DEAD; m_dead_left = DEAD_CYCLES;
                    end else begin
                        m_since++;
                        if (m_since % RAMP_DIV == 0) m_pwm = step_toward(m_pwm, goal);
                    end
                end
            end
            M_DEAD: begin
                if (hf) go_fault(1);
                else if (!enable) go_idle();
                else begin
                    m_hbad = nh; m_stall = 0;
                    m_dead_left--;
                    if (m_dead_left == 0) begin
                        m_dir = 1 - m_dir; m_st = M_RUN; m_since = 0;
                    end
                end
            end
            default: if (!enable) go_idle();
        endcase
        m_prev = m_sync;
        m_sync = m_meta;
        m_meta = {hall1, hall2, hall3};
    endtask

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_st = M_IDLE; m_pwm = 0; m_dir = 0; m_code = 0;
            m_meta = 0; m_sync = 0; m_prev = 0;
            m_since = 0; m_dead_left = 0; m_hbad = 0; m_stall = 0;
            exp_q.delete();
        end else begin
            model_step();
            exp_q.push_back('{m_pwm, m_dir, m_st, (m_st == M_FAULT) ? 1 : 0, m_code, m_sync});
        end
    end

    always @(negedge CLK) begin
        if (RESET_N) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty t=%0t no expected entry for DUT output", $time);
            end else begin
                e = exp_q.pop_front();
                if (int'(pwm_cmd) != e.pwm || int'(dir) != e.dir || int'(state) != e.st ||
                    int'(fault) != e.flt || int'(fault_code) != e.code || int'(hall_sync) != e.hs) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t actual pwm=%0d dir=%0d st=%0d flt=%0d code=%0d hs=%0d required pwm=%0d dir=%0d st=%0d flt=%0d code=%0d hs=%0d",
                             $time, pwm_cmd, dir, state, fault, fault_code, hall_sync,
                             e.pwm, e.dir, e.st, e.flt, e.code, e.hs);
                end
            end
        end
    end

    // Hall stimulus: rotate through valid codes every 10 cycles, or hold a forced code.
    logic [2:0] hall_seq [6];
    logic [2:0] hall_force = 3'b101;
    int hall_idx = 0, hall_tick = 0, hall_mode = 0;

    always @(negedge CLK) begin
        if (hall_mode == 0) begin
            hall_tick++;
            if (hall_tick >= 10) begin
                hall_tick = 0;
                hall_idx = (hall_idx + 1) % 6;
            end
            {hall1, hall2, hall3} = hall_seq[hall_idx];
        end else begin
            {hall1, hall2, hall3} = hall_force;
        end
    end

    task automatic check_eq(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_state(input int s, input int budget, input string name);
        int k;
        k = 0;
        while (int'(state) != s && k < budget) begin
            @(negedge CLK);
            k++;
        end
        check_eq(name, int'(state), s);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_pwm"}, int'(pwm_cmd), 0);
        check_eq({tag, "_dir"}, int'(dir), 0);
        check_eq({tag, "_state"}, int'(state), 0);
        check_eq({tag, "_fault"}, int'(fault), 0);
        check_eq({tag, "_code"}, int'(fault_code), 0);
        check_eq({tag, "_hall_sync"}, int'(hall_sync), 0);
    endtask

    initial begin
        #500000;
        n_fail++;
        $display("FAIL global_timeout t=%0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        int r, t;
        hall_seq = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
        #1 RESET_N = 1'b0;
        #2 check_reset_outputs("reset");
        @(negedge CLK);
        #2 RESET_N = 1'b1;
        cyc(3);

        // ramp up, saturate positive, then full swing to -1023
        target_pwm = 11'sd250; enable = 1'b1;
        cyc(20);
        target_pwm = 11'sd1023;
        cyc(60);
        target_pwm = -11'sd1024;
        cyc(120);

        // reversal from +200 to -150
        target_pwm = 11'sd200;
        cyc(150);
        target_pwm = -11'sd150;
        wait_state(M_DEAD, 100, "reach_dead");
        cyc(40);

        // hall fault with enable held, then clear
        hall_force = 3'b111; hall_mode = 1;
        wait_state(M_FAULT, 20, "hall_fault");
        check_eq("hall_fault_code", int'(fault_code), 1);
        cyc(5);
        enable = 1'b0;
        cyc(2);
        hall_mode = 0;
        enable = 1'b1;

        // stall with a single hall change partway through
        target_pwm = 11'sd100;
        cyc(20);
        hall_force = 3'b101; hall_mode = 1;
        cyc(60);
        hall_force = 3'b100;
        cyc(1);
        hall_force = 3'b101;
        wait_state(M_FAULT, 100, "stall_fault");
        check_eq("stall_fault_code", int'(fault_code), 2);
        enable = 1'b0; hall_mode = 0;
        cyc(3);

        // disable mid-ramp
        enable = 1'b1; target_pwm = 11'sd1000;
        cyc(13);
        enable = 1'b0;
        cyc(3);

        // randomized segments
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2) t = (r == 0) ? 1023 : -1024;
            else if (r < 4) t = int'($urandom_range(0, 20)) - 10;
            else t = int'($urandom_range(0, 2047)) - 1024;
            target_pwm = 11'(t);
            enable = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0) begin
                hall_force = ($urandom_range(0, 1) != 0) ? 3'b111 : 3'b000;
                hall_mode = 1;
                cyc(int'($urandom_range(1, 6)));
                hall_mode = 0;
            end
            cyc(int'($urandom_range(5, 60)));
        end

        // asynchronous reset while in DEAD
        enable = 1'b0; hall_mode = 0;
        cyc(2);
        enable = 1'b1; target_pwm = 11'sd500;
        cyc(40);
        target_pwm = -11'sd500;
        wait_state(M_DEAD, 100, "dead_before_reset");
        cyc(3);
        @(posedge CLK);
        #2 RESET_N = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(negedge CLK);
        #2 RESET_N = 1'b1;
        cyc(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
